exec_wb_sequencer: RTL and testbench
====================================

Name: exec_wb_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit RISC core.
- Accepts one instruction at a time over a valid/ready handshake, decodes it and starts the ALU.
- Steers the registered writeback mux between the 32-bit ALU result (select=1) and the zero-extended 16-bit immediate (select=0).
- Pulses the register-file write enable once the mux output is valid, then advances the PC.

Parameters:
PC_W, 8, width of program counter; wraps modulo 2^PC_W
TIMEOUT, 16, max cycles waiting for ALU_DONE before abort (>=2)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
INSTR_VALID  input  1  INSTR holds a valid instruction
INSTR  input  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; [7:0] imm for LDI
INSTR_READY  output  1  sequencer can accept an instruction
ALU_DONE  input  1  ALU result valid (single-cycle pulse)
ALU_START  output  1  one-cycle ALU start pulse
ALU_OP  output  4  opcode forwarded to ALU, held from DECODE until IDLE
RF_RADDR1  output  4  rs1
RF_RADDR2  output  4  rs2
RF_WADDR  output  4  rd, held until IDLE
RF_WE  output  1  register-file write strobe
IMM  output  16  {8'h00, imm8} to mux immediate input
MUXA_SEL  output  1  1 = ALU result, 0 = immediate
PC  output  PC_W  program counter
BUSY  output  1  not in IDLE/HALT
HALTED  output  1  HLT executed
ERR  output  1  one-cycle pulse on illegal opcode or ALU timeout

Behaviour:
- Reset (async, RST_N=0): state IDLE; all outputs 0 except INSTR_READY=1. Reset mid-instruction aborts with no RF_WE.
- Opcodes:
  - 0x0 NOP
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR, 0x6 MUL (ALU class)
  - 0x7 LDI
  - 0xF HLT
  - 0x8-0xE illegal
- Handshake: transfer when INSTR_VALID && INSTR_READY at a rising edge. INSTR_READY=1 only in IDLE. INSTR is latched on transfer; later changes are ignored.
- States:
  - IDLE -> DECODE on transfer.
  - DECODE (1 cycle): latch fields, drive RADDRs/ALU_OP/WADDR/IMM.
    - ALU class -> EXEC.
    - LDI -> MUX.
    - NOP -> IDLE with PC+1.
    - Illegal -> IDLE, ERR=1, PC+1.
    - HLT -> HALT, HALTED=1.
  - EXEC: ALU_START=1 on the first EXEC cycle only. Cycle counter starts at 0.
    - ALU_DONE=1 -> MUX.
    - Counter reaching TIMEOUT-1 without ALU_DONE -> IDLE, ERR=1, no RF_WE, PC unchanged.
    - ALU_DONE in the same cycle as the timeout: done wins.
    - ALU_DONE during DECODE/IDLE is ignored.
  - MUX (1 cycle): MUXA_SEL=1 for ALU class, 0 for LDI. The mux registers its output on this cycle's edge.
  - WB (1 cycle): MUXA_SEL held; RF_WE=1; PC<=PC+1 -> IDLE.
  - HALT: terminal until reset; INSTR_READY=0, BUSY=0.
- MUXA_SEL keeps its last value in IDLE (no glitching between instructions).
- Latency, transfer edge = cycle 0:
  - LDI: RF_WE at cycle 3, INSTR_READY again at cycle 4.
  - ALU op with ALU_DONE in first EXEC cycle: ALU_START at cycle 2, RF_WE at cycle 4, ready at cycle 5.
- PC wraps 2^PC_W-1 -> 0.
- ERR and RF_WE are never both asserted.

Test Plan:
- Reset then LDI rd=3 imm=0xA5 -> DECODE/MUX/WB sequence; MUXA_SEL=0; IMM=0x00A5; RF_WE single pulse at cycle 3 with RF_WADDR=3; PC 0->1.
- ADD rd=2 rs1=4 rs2=5, ALU_DONE 3 cycles after ALU_START -> ALU_START one pulse; RADDR1=4, RADDR2=5; MUXA_SEL=1 then RF_WE; PC+1; INSTR_VALID held high during BUSY causes no second transfer.
- MUL with ALU_DONE never asserted, TIMEOUT=16 -> ERR pulse after 16 EXEC cycles; no RF_WE; PC unchanged; INSTR_READY=1 next cycle.
- Opcode 0x9 then NOP -> ERR pulse, PC+1 each, no ALU_START, no RF_WE.
- PC=8'hFF then LDI -> PC=0x00; then HLT -> HALTED=1, INSTR_READY=0 indefinitely despite INSTR_VALID.
- RST_N low during EXEC of SUB -> immediately IDLE, all outputs reset; ALU_DONE arriving after reset produces no RF_WE.

Source files
------------

// File: rtl/exec_wb_sequencer.sv
// exec_wb_sequencer: multi-cycle execute/writeback controller for the 16-bit
// RISC core. Takes one instruction per valid/ready handshake, starts the ALU,
// steers the registered writeback mux, strobes the register file and advances
// the PC. All outputs are registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for an instruction; mux select keeps its last value
// S_DECODE | fields latched and driven; classify opcode
// S_EXEC   | ALU running; timeout down-counter armed
// S_MUX    | mux select valid; writeback mux registers on this edge
// S_WB     | register-file write strobe; PC advances on exit
// S_HALT   | HLT executed; terminal until reset
module exec_wb_sequencer #(
   parameter int PC_W    = 8,
   parameter int TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            instr_valid_i,
   input  logic [15:0]     instr_i,
   output logic            instr_ready_o,
   input  logic            alu_done_i,
   output logic            alu_start_o,
   output logic [3:0]      alu_op_o,
   output logic [3:0]      rf_raddr1_o,
   output logic [3:0]      rf_raddr2_o,
   output logic [3:0]      rf_waddr_o,
   output logic            rf_we_o,
   output logic [15:0]     imm_o,
   output logic            muxa_sel_o,
   output logic [PC_W-1:0] pc_o,
   output logic            busy_o,
   output logic            halted_o,
   output logic            err_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_MUL = 4'h6;
   localparam logic [3:0] OP_LDI = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MUX    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             instr_ready_q;
   logic             alu_start_q;
   logic [3:0]       alu_op_q;
   logic [3:0]       rf_raddr1_q;
   logic [3:0]       rf_raddr2_q;
   logic [3:0]       rf_waddr_q;
   logic             rf_we_q;
   logic [15:0]      imm_q;
   logic             muxa_sel_q;
   logic [PC_W-1:0]  pc_q;
   logic             busy_q;
   logic             halted_q;
   logic             err_q;

   // Sequencer FSM with registered outputs; timeout is a down-counter that
   // gives the ALU exactly TIMEOUT EXEC cycles, with ALU_DONE winning a tie.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         instr_ready_q <= 1'b1;
         alu_start_q   <= 1'b0;
         alu_op_q      <= '0;
         rf_raddr1_q   <= '0;
         rf_raddr2_q   <= '0;
         rf_waddr_q    <= '0;
         rf_we_q       <= 1'b0;
         imm_q         <= '0;
         muxa_sel_q    <= 1'b0;
         pc_q          <= '0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         // Pulse outputs default low each cycle.
         alu_start_q <= 1'b0;
         rf_we_q     <= 1'b0;
         err_q       <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (instr_valid_i) begin
                  state_q       <= S_DECODE;
                  instr_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
                  alu_op_q      <= instr_i[15:12];
                  rf_waddr_q    <= instr_i[11:8];
                  rf_raddr1_q   <= instr_i[7:4];
                  rf_raddr2_q   <= instr_i[3:0];
                  imm_q         <= {8'h00, instr_i[7:0]};
               end
            end

            S_DECODE: begin
               case (alu_op_q)
                  OP_NOP: begin
                     state_q       <= S_IDLE;
                     instr_ready_q <= 1'b1;
                     busy_q        <= 1'b0;
                     pc_q          <= pc_q + PC_W'(1);
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: begin
                     state_q     <= S_EXEC;
                     alu_start_q <= 1'b1;
                     cnt_q       <= CNT_W'(TIMEOUT - 1);
                  end
                  OP_LDI: begin
                     state_q    <= S_MUX;
                     muxa_sel_q <= 1'b0;
                  end
                  OP_HLT: begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                     busy_q   <= 1'b0;
                  end
                  default: begin
                     state_q       <= S_IDLE;
                     err_q         <= 1'b1;
                     instr_ready_q <= 1'b1;
                     busy_q        <= 1'b0;
                     pc_q          <= pc_q + PC_W'(1);
                  end
               endcase
            end

            S_EXEC: begin
               if (alu_done_i) begin
                  state_q    <= S_MUX;
                  muxa_sel_q <= 1'b1;
               end else if (cnt_q == '0) begin
                  // Abort: no writeback and the PC stays on this instruction.
                  state_q       <= S_IDLE;
                  err_q         <= 1'b1;
                  instr_ready_q <= 1'b1;
                  busy_q        <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            S_MUX: begin
               state_q <= S_WB;
               rf_we_q <= 1'b1;
            end

            S_WB: begin
               state_q       <= S_IDLE;
               instr_ready_q <= 1'b1;
               busy_q        <= 1'b0;
               pc_q          <= pc_q + PC_W'(1);
            end

            S_HALT: begin
               state_q <= S_HALT;
            end

            default: begin
               state_q       <= S_IDLE;
               instr_ready_q <= 1'b1;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign instr_ready_o = instr_ready_q;
   assign alu_start_o   = alu_start_q;
   assign alu_op_o      = alu_op_q;
   assign rf_raddr1_o   = rf_raddr1_q;
   assign rf_raddr2_o   = rf_raddr2_q;
   assign rf_waddr_o    = rf_waddr_q;
   assign rf_we_o       = rf_we_q;
   assign imm_o         = imm_q;
   assign muxa_sel_o    = muxa_sel_q;
   assign pc_o          = pc_q;
   assign busy_o        = busy_q;
   assign halted_o      = halted_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_exec_wb_sequencer.sv
// Testbench for exec_wb_sequencer: table of instruction vectors driven through
// a handshake driver that plays the ALU, plus a scoreboard of expected
// writeback/error events checked by a monitor, plus hand-written sequences
// for halt, PC wrap and mid-instruction reset.
module tb_exec_wb_sequencer;

   logic        clk_i;
   logic        rst_n_i;
   logic        instr_valid_i;
   logic [15:0] instr_i;
   logic        instr_ready_o;
   logic        alu_done_i;
   logic        alu_start_o;
   logic [3:0]  alu_op_o;
   logic [3:0]  rf_raddr1_o;
   logic [3:0]  rf_raddr2_o;
   logic [3:0]  rf_waddr_o;
   logic        rf_we_o;
   logic [15:0] imm_o;
   logic        muxa_sel_o;
   logic [7:0]  pc_o;
   logic        busy_o;
   logic        halted_o;
   logic        err_o;

   exec_wb_sequencer #(.PC_W(8), .TIMEOUT(16)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .instr_valid_i (instr_valid_i),
      .instr_i       (instr_i),
      .instr_ready_o (instr_ready_o),
      .alu_done_i    (alu_done_i),
      .alu_start_o   (alu_start_o),
      .alu_op_o      (alu_op_o),
      .rf_raddr1_o   (rf_raddr1_o),
      .rf_raddr2_o   (rf_raddr2_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_we_o       (rf_we_o),
      .imm_o         (imm_o),
      .muxa_sel_o    (muxa_sel_o),
      .pc_o          (pc_o),
      .busy_o        (busy_o),
      .halted_o      (halted_o),
      .err_o         (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] instr;
      int          done_dly;   // cycles after ALU_START that ALU_DONE pulses
      int          exp_ticks;  // edges after transfer until INSTR_READY returns
      int          exp_start;
      int          exp_we;
      int          exp_err;
      int          exp_muxa;
      int          pc_inc;
      int          hold_valid; // keep INSTR_VALID high while busy
      int          early_done; // pulse ALU_DONE during DECODE
   } vec_t;

   typedef struct {
      int         is_err;
      logic [3:0] waddr;
      int         muxa;
      logic [7:0] pc;
      int         at;
   } exp_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [7:0] pc_m    = 8'h00;
   int         last_muxa = 0;
   exp_t       sb[$];
   exp_t       mon_e;
   vec_t       vecs[14];
   vec_t       nop_v;
   vec_t       tmp_v;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: every RF_WE or ERR pulse must match the oldest expected event.
   always @(negedge clk_i) begin
      if (rf_we_o && err_o)
         check("we_err_exclusive", 32'(rf_we_o & err_o), 32'd0);
      if (rf_we_o || err_o) begin
         if (sb.size() == 0) begin
            check("unexpected_event", {30'd0, rf_we_o, err_o}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("sb_is_err", 32'(err_o), 32'(mon_e.is_err));
            check("sb_cycle", 32'(cyc), 32'(mon_e.at));
            check("sb_pc", 32'(pc_o), 32'(mon_e.pc));
            if (mon_e.is_err == 0) begin
               check("sb_waddr", 32'(rf_waddr_o), 32'(mon_e.waddr));
               check("sb_muxa", 32'(muxa_sel_o), 32'(mon_e.muxa));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int   guard;
      int   ticks;
      int   starts;
      int   since;
      exp_t e;
      guard = 0;
      while (!instr_ready_o && guard < 50) begin
         tick();
         guard++;
      end
      check("ready_before_xfer", 32'(instr_ready_o), 32'd1);
      instr_valid_i = 1'b1;
      instr_i       = v.instr;
      tick();
      if (v.exp_we != 0 || v.exp_err != 0) begin
         e.is_err = v.exp_err;
         e.waddr  = v.instr[11:8];
         e.muxa   = v.exp_muxa;
         e.pc     = (v.exp_we != 0) ? pc_m : pc_m + 8'(v.pc_inc);
         e.at     = (v.exp_we != 0) ? cyc + v.exp_ticks - 1 : cyc + v.exp_ticks;
         sb.push_back(e);
      end
      if (v.hold_valid == 0) instr_valid_i = 1'b0;
      instr_i = 16'($urandom);
      check("dec_raddr1", 32'(rf_raddr1_o), 32'(v.instr[7:4]));
      check("dec_raddr2", 32'(rf_raddr2_o), 32'(v.instr[3:0]));
      check("dec_waddr", 32'(rf_waddr_o), 32'(v.instr[11:8]));
      check("dec_alu_op", 32'(alu_op_o), 32'(v.instr[15:12]));
      check("dec_imm", 32'(imm_o), {24'd0, v.instr[7:0]});
      check("dec_busy", 32'(busy_o), 32'd1);
      check("dec_ready", 32'(instr_ready_o), 32'd0);
      ticks  = 0;
      starts = 0;
      since  = -1;
      while (!instr_ready_o && ticks < 100) begin
         if (alu_start_o) begin
            starts++;
            since = 0;
         end else if (since >= 0) begin
            since++;
         end
         alu_done_i = (since >= 0 && since == v.done_dly) ||
                      (v.early_done != 0 && ticks == 0);
         tick();
         ticks++;
         instr_i = 16'($urandom);
      end
      alu_done_i    = 1'b0;
      instr_valid_i = 1'b0;
      if (v.exp_we != 0) last_muxa = v.exp_muxa;
      pc_m = pc_m + 8'(v.pc_inc);
      check("latency_ticks", 32'(ticks), 32'(v.exp_ticks));
      check("alu_start_count", 32'(starts), 32'(v.exp_start));
      check("pc_after", 32'(pc_o), 32'(pc_m));
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_muxa_held", 32'(muxa_sel_o), 32'(last_muxa));
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ready"}, 32'(instr_ready_o), 32'd1);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_start"}, 32'(alu_start_o), 32'd0);
      check({tag, "_we"}, 32'(rf_we_o), 32'd0);
      check({tag, "_err"}, 32'(err_o), 32'd0);
      check({tag, "_halted"}, 32'(halted_o), 32'd0);
      check({tag, "_pc"}, 32'(pc_o), 32'd0);
      check({tag, "_muxa"}, 32'(muxa_sel_o), 32'd0);
      check({tag, "_alu_op"}, 32'(alu_op_o), 32'd0);
      check({tag, "_waddr"}, 32'(rf_waddr_o), 32'd0);
      check({tag, "_raddrs"}, {24'd0, rf_raddr1_o, rf_raddr2_o}, 32'd0);
      check({tag, "_imm"}, 32'(imm_o), 32'd0);
   endtask

   initial begin
      //          instr     dly ticks st we er mx inc hold early
      vecs[0]  = '{16'h73A5,  0,  3,  0, 1, 0, 0, 1, 0, 0};  // LDI r3,0xA5
      vecs[1]  = '{16'h1245,  3,  7,  1, 1, 0, 1, 1, 1, 0};  // ADD, valid held
      vecs[2]  = '{16'h6ABC, 99, 17,  1, 0, 1, 0, 0, 0, 0};  // MUL timeout
      vecs[3]  = '{16'h9123,  0,  1,  0, 0, 1, 0, 1, 0, 0};  // illegal 0x9
      vecs[4]  = '{16'h0000,  0,  1,  0, 0, 0, 0, 1, 0, 0};  // NOP
      vecs[5]  = '{16'h5E12,  0,  4,  1, 1, 0, 1, 1, 0, 0};  // XOR, done at once
      vecs[6]  = '{16'h3777, 15, 19,  1, 1, 0, 1, 1, 0, 0};  // AND, done on last cycle
      vecs[7]  = '{16'h4111, 16, 17,  1, 0, 1, 0, 0, 0, 0};  // OR, done one too late
      vecs[8]  = '{16'hEFFF,  0,  1,  0, 0, 1, 0, 1, 0, 0};  // illegal 0xE
      vecs[9]  = '{16'h7F00,  0,  3,  0, 1, 0, 0, 1, 0, 0};  // LDI r15,0x00
      vecs[10] = '{16'h2A01,  1,  5,  1, 1, 0, 1, 1, 0, 0};  // SUB
      vecs[11] = '{16'h8000,  0,  1,  0, 0, 1, 0, 1, 0, 0};  // illegal 0x8
      vecs[12] = '{16'h1321,  2,  6,  1, 1, 0, 1, 1, 0, 1};  // ADD, DONE in DECODE ignored
      vecs[13] = '{16'h0FFF,  0,  1,  0, 0, 0, 0, 1, 1, 0};  // NOP, valid held
      nop_v    = '{16'h0000,  0,  1,  0, 0, 0, 0, 1, 0, 0};

      rst_n_i       = 1'b0;
      instr_valid_i = 1'b0;
      instr_i       = 16'h0000;
      alu_done_i    = 1'b0;
      tick();
      check_reset_outputs("por");
      tick();
      rst_n_i = 1'b1;
      tick();
      check_reset_outputs("after_por");

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // Advance the PC to 0xFF with NOPs, then LDI wraps it to 0x00.
      while (pc_m != 8'hFF) run_vec(nop_v);
      check("pc_at_ff", 32'(pc_o), 32'h0000_00FF);
      tmp_v = '{16'h7C3C, 0, 3, 0, 1, 0, 0, 1, 0, 0};
      run_vec(tmp_v);
      check("pc_wrapped", 32'(pc_o), 32'd0);

      // HLT: terminal, ignores INSTR_VALID indefinitely.
      instr_valid_i = 1'b1;
      instr_i       = 16'hF000;
      tick();
      check("hlt_dec_busy", 32'(busy_o), 32'd1);
      tick();
      check("hlt_halted", 32'(halted_o), 32'd1);
      check("hlt_busy", 32'(busy_o), 32'd0);
      for (int i = 0; i < 20; i++) begin
         instr_i = {4'h7, 12'($urandom)};
         tick();
         check("hlt_ready_low", 32'(instr_ready_o), 32'd0);
         check("hlt_stays", 32'(halted_o), 32'd1);
         check("hlt_pc", 32'(pc_o), 32'(pc_m));
      end
      instr_valid_i = 1'b0;

      // Reset leaves HALT.
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("halt_rst");
      tick();
      rst_n_i   = 1'b1;
      pc_m      = 8'h00;
      last_muxa = 0;
      tmp_v = '{16'h7155, 0, 3, 0, 1, 0, 0, 1, 0, 0};
      run_vec(tmp_v);

      // Reset in the middle of SUB's EXEC phase; late ALU_DONE must not write.
      instr_valid_i = 1'b1;
      instr_i       = 16'h2345;
      tick();
      instr_valid_i = 1'b0;
      begin
         int g;
         g = 0;
         while (!alu_start_o && g < 10) begin
            tick();
            g++;
         end
         check("mid_rst_saw_start", 32'(alu_start_o), 32'd1);
      end
      tick();
      tick();
      check("mid_rst_busy_before", 32'(busy_o), 32'd1);
      #2;
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      rst_n_i   = 1'b1;
      pc_m      = 8'h00;
      last_muxa = 0;
      for (int i = 0; i < 6; i++) begin
         alu_done_i = (i == 1 || i == 3);
         tick();
         check("post_rst_no_start", 32'(alu_start_o), 32'd0);
         check("post_rst_ready", 32'(instr_ready_o), 32'd1);
         check("post_rst_pc", 32'(pc_o), 32'd0);
      end
      alu_done_i = 1'b0;

      tmp_v = '{16'h1B67, 0, 4, 1, 1, 0, 1, 1, 0, 0};
      run_vec(tmp_v);

      tick();
      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
